// File: rtl/mem_stream_pkg.sv
// Shared types and constants for the mem_stream_reader block.
// Holds the controller state encoding and the output buffer depth.
package mem_stream_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    localparam int MEM_STREAM_BUF_DEPTH = 2;

    // Wide enough to hold 0..MEM_STREAM_BUF_DEPTH.
    localparam int MEM_STREAM_CNT_W = $clog2(MEM_STREAM_BUF_DEPTH + 1);

endpackage

// File: rtl/mem_stream_fifo2.sv
// Two-entry synchronous FIFO with occupancy count.
// It is used as the output buffer of mem_stream_reader.
module mem_stream_fifo2
    import mem_stream_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic                        clock,
    input  logic                        rst_n,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            head_data,
    output logic [MEM_STREAM_CNT_W-1:0] count
);

    logic [WIDTH-1:0] store [MEM_STREAM_BUF_DEPTH];
    logic             rd_ptr;
    logic             wr_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_pop  = pop && (count != '0);
    assign do_push = push && ((count < MEM_STREAM_CNT_W'(MEM_STREAM_BUF_DEPTH)) || do_pop);

    assign head_data = store[rd_ptr];

    // Storage is cleared on reset so the head reads zero while empty.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_STREAM_BUF_DEPTH; i++) begin
                store[i] <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                store[wr_ptr] <= push_data;
                wr_ptr        <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + MEM_STREAM_CNT_W'(do_push) - MEM_STREAM_CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/mem_stream_reader.sv
// Sequential RAM read engine that streams a contiguous address range downstream.
// Define MEM_STREAM_WRAP_EN for circular reads instead of range rejection.
module mem_stream_reader
    import mem_stream_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 65704,
    localparam int AW = $clog2(DEPTH),
    localparam int LW = $clog2(DEPTH + 1)
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             start,
    input  logic [AW-1:0]    start_addr,
    input  logic [LW-1:0]    length,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [AW-1:0]    mem_address,
    output logic             mem_wr_en,
    output logic [WIDTH-1:0] mem_data,
    input  logic [WIDTH-1:0] mem_q,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t                      state;
    state_t                      state_next;
    logic [LW-1:0]               len_q;
    logic [LW-1:0]               issued;
    logic [LW-1:0]               accepted;
    logic                        in_flight;
    logic                        err_q;
    logic                        range_ok;
    logic                        start_accept;
    logic                        go_run;
    logic                        pop;
    logic                        credit;
    logic                        issue;
    logic                        last_pop;
    logic [AW-1:0]               addr_next;
    logic [MEM_STREAM_CNT_W-1:0] fifo_count;

`ifdef MEM_STREAM_WRAP_EN
    assign range_ok = (length <= LW'(DEPTH));
`else
    logic [LW:0] range_end;

    // One extra bit so the end address can never overflow.
    assign range_end = (LW + 1)'(start_addr) + (LW + 1)'(length);
    assign range_ok  = (range_end <= (LW + 1)'(DEPTH));
`endif

    assign start_accept = (state == IDLE) && start;
    assign go_run       = start_accept && (length != '0) && range_ok;
    assign pop          = out_valid && out_ready;

    // Words already buffered or on their way must fit the buffer after this cycle's pop.
    assign credit = ({1'b0, fifo_count} + 3'(in_flight))
                    < (3'(MEM_STREAM_BUF_DEPTH) + 3'(pop));
    assign issue    = (state == RUN) && (issued != len_q) && credit;
    assign last_pop = pop && (accepted == (len_q - LW'(1)));

    assign addr_next = (mem_address == AW'(DEPTH - 1)) ? '0 : mem_address + AW'(1);

    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);
    assign err       = done && err_q;
    assign mem_wr_en = 1'b0;
    assign mem_data  = '0;
    assign out_valid = (fifo_count != '0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = go_run ? RUN : FINISH;
                end
            end
            RUN: begin
                if (last_pop) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            mem_address <= '0;
            len_q       <= '0;
            issued      <= '0;
            accepted    <= '0;
            in_flight   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state     <= state_next;
            in_flight <= issue;
            if (start_accept) begin
                err_q <= (length != '0) && !range_ok;
            end
            if (go_run) begin
                mem_address <= start_addr;
                len_q       <= length;
                issued      <= '0;
                accepted    <= '0;
            end else begin
                if (issue) begin
                    mem_address <= addr_next;
                    issued      <= issued + LW'(1);
                end
                if (pop) begin
                    accepted <= accepted + LW'(1);
                end
            end
        end
    end

    // The RAM's registered output lands in the buffer one cycle after each issue.
    mem_stream_fifo2 #(
        .WIDTH(WIDTH)
    ) u_out_buf (
        .clock     (clock),
        .rst_n     (rst_n),
        .push      (in_flight),
        .push_data (mem_q),
        .pop       (pop),
        .head_data (out_data),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_mem_stream_reader.sv
// Scoreboard bench for mem_stream_reader with a behavioural mem_single model (word[i] = i).
// Expected words and done pulses are queued at stimulus time and checked by a monitor.
module tb_mem_stream_reader;

    localparam int WIDTH = 64;
    localparam int DEPTH = 65704;
    localparam int AW    = $clog2(DEPTH);
    localparam int LW    = $clog2(DEPTH + 1);

    logic             clock = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [AW-1:0]    start_addr = '0;
    logic [LW-1:0]    length = '0;
    logic             busy;
    logic             done;
    logic             err;
    logic [AW-1:0]    mem_address;
    logic             mem_wr_en;
    logic [WIDTH-1:0] mem_data;
    logic [WIDTH-1:0] mem_q = '0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready = 1'b1;

    typedef struct {
        logic [WIDTH-1:0] data;
        longint           cyc;
    } word_exp_t;

    typedef struct {
        logic   err;
        longint cyc;
    } done_exp_t;

    word_exp_t        exp_q[$];
    done_exp_t        done_q[$];
    int               checks = 0;
    int               failures = 0;
    longint           cyc = 0;
    longint           t0 = 0;
    int               pop_count = 0;
    bit               ready_mode = 1'b0;
    int               pat_idx = 0;
    logic [3:0]       pat = 4'b1001;
    bit               track_outstanding = 1'b0;
    int               track_base = 0;
    int               max_outstanding = 0;
    logic             prev_valid = 1'b0;
    logic             prev_ready = 1'b0;
    logic [WIDTH-1:0] prev_data = '0;
    logic [AW-1:0]    addr_before;

    mem_stream_reader dut (
        .clock       (clock),
        .rst_n       (rst_n),
        .start       (start),
        .start_addr  (start_addr),
        .length      (length),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .mem_address (mem_address),
        .mem_wr_en   (mem_wr_en),
        .mem_data    (mem_data),
        .mem_q       (mem_q),
        .out_data    (out_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    always #5 clock = ~clock;

    always @(posedge clock) begin
        cyc   <= cyc + 1;
        mem_q <= WIDTH'(mem_address);
    end

    // Downstream ready: constant high, or the repeating 1,0,0,1 pattern.
    always @(posedge clock) begin
        #1;
        if (ready_mode) begin
            out_ready = pat[pat_idx];
            pat_idx   = (pat_idx + 1) % 4;
        end else begin
            out_ready = 1'b1;
        end
    end

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at cycle %0d",
                     name, actual, expected, cyc);
        end
    endtask

    task automatic report_fail(input string name);
        checks++;
        failures++;
        $display("[TB] FAIL %s at cycle %0d", name, cyc);
    endtask

    // Monitor: compares every accepted word and every done pulse against the queues.
    always @(negedge clock) begin
        int outst;
        word_exp_t w;
        done_exp_t d;
        if (rst_n) begin
            if (prev_valid && !prev_ready) begin
                check_output("hold_valid", 64'(out_valid), 64'd1);
                check_output("hold_data", out_data, prev_data);
            end
            if (track_outstanding) begin
                outst = int'(mem_address) - track_base - pop_count;
                if (outst > max_outstanding) max_outstanding = outst;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    report_fail("unexpected_word");
                end else begin
                    w = exp_q.pop_front();
                    check_output("word_data", out_data, w.data);
                    if (w.cyc >= 0) check_output("word_cycle", 64'(cyc), 64'(w.cyc));
                end
                pop_count++;
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    report_fail("unexpected_done");
                end else begin
                    d = done_q.pop_front();
                    check_output("done_err", 64'(err), 64'(d.err));
                    if (d.cyc >= 0) check_output("done_cycle", 64'(cyc), 64'(d.cyc));
                end
            end else if (err) begin
                report_fail("err_without_done");
            end
        end
        prev_valid = out_valid && rst_n;
        prev_ready = out_ready;
        prev_data  = out_data;
    end

    task automatic apply_stimulus(input int addr, input int len, input bit timed,
                                  input bit exp_err);
        word_exp_t w;
        done_exp_t d;
        @(posedge clock);
        #1;
        start      = 1'b1;
        start_addr = AW'(addr);
        length     = LW'(len);
        t0         = cyc;
        pop_count  = 0;
        if (exp_err || len == 0) begin
            d.err = exp_err;
            d.cyc = t0 + 1;
            done_q.push_back(d);
        end else begin
            for (int k = 0; k < len; k++) begin
                w.data = WIDTH'((addr + k) % DEPTH);
                w.cyc  = timed ? t0 + 3 + k : -1;
                exp_q.push_back(w);
            end
            d.err = 1'b0;
            d.cyc = timed ? t0 + len + 3 : -1;
            done_q.push_back(d);
        end
        @(posedge clock);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 400 && (exp_q.size() != 0 || done_q.size() != 0); i++) begin
            @(posedge clock);
        end
        if (exp_q.size() != 0 || done_q.size() != 0) begin
            report_fail("transfer_timeout");
            exp_q.delete();
            done_q.delete();
        end
        @(posedge clock);
        #1;
        check_output("busy_after_done", 64'(busy), 64'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_busy"}, 64'(busy), 64'd0);
        check_output({tag, "_done"}, 64'(done), 64'd0);
        check_output({tag, "_err"}, 64'(err), 64'd0);
        check_output({tag, "_out_valid"}, 64'(out_valid), 64'd0);
        check_output({tag, "_out_data"}, out_data, 64'd0);
        check_output({tag, "_mem_address"}, 64'(mem_address), 64'd0);
        check_output({tag, "_mem_wr_en"}, 64'(mem_wr_en), 64'd0);
        check_output({tag, "_mem_data"}, mem_data, 64'd0);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        $display("[TB] starting");
        repeat (3) @(posedge clock);
        #1;
        check_reset_values("reset");
        rst_n = 1'b1;

        // Eight words from address 100 at full rate.
        apply_stimulus(100, 8, 1'b1, 1'b0);
        check_output("run_busy_c1", 64'(busy), 64'd1);
        check_output("run_addr_c1", 64'(mem_address), 64'd100);
        wait_idle();

        // Same transfer under the 1,0,0,1 ready pattern.
        ready_mode = 1'b1;
        max_outstanding = 0;
        track_base = 100;
        apply_stimulus(100, 8, 1'b0, 1'b0);
        track_outstanding = 1'b1;
        wait_idle();
        track_outstanding = 1'b0;
        ready_mode = 1'b0;
        check_output("max_outstanding", 64'(max_outstanding), 64'd2);

        // Zero-length transfer.
        apply_stimulus(50, 0, 1'b1, 1'b0);
        check_output("len0_busy_c1", 64'(busy), 64'd1);
        @(posedge clock);
        #1;
        check_output("len0_busy_c2", 64'(busy), 64'd0);
        wait_idle();

        // Range crossing the end of memory.
        addr_before = mem_address;
`ifdef MEM_STREAM_WRAP_EN
        apply_stimulus(DEPTH - 2, 4, 1'b1, 1'b0);
        wait_idle();
`else
        apply_stimulus(DEPTH - 2, 4, 1'b1, 1'b1);
        check_output("reject_addr_c1", 64'(mem_address), 64'(addr_before));
        wait_idle();
        check_output("reject_addr_end", 64'(mem_address), 64'(addr_before));
`endif

        // Length beyond DEPTH is rejected in either build.
        apply_stimulus(0, DEPTH + 1, 1'b1, 1'b1);
        wait_idle();

        // Second start while busy must be ignored.
        apply_stimulus(200, 8, 1'b1, 1'b0);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        start      = 1'b1;
        start_addr = AW'(500);
        length     = LW'(2);
        @(posedge clock);
        #1;
        start = 1'b0;
        wait_idle();

        // Reset in the middle of a 16-word transfer.
        apply_stimulus(300, 16, 1'b0, 1'b0);
        for (int i = 0; i < 100 && pop_count < 3; i++) @(posedge clock);
        if (pop_count < 3) report_fail("midreset_wait_timeout");
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        done_q.delete();
        #1;
        check_reset_values("midreset");
        repeat (2) @(posedge clock);
        #1;
        check_reset_values("midreset_hold");
        rst_n = 1'b1;
        apply_stimulus(20, 4, 1'b1, 1'b0);
        wait_idle();

        repeat (3) @(posedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
